// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command scheduler and its FIFO.
package uart_cmd_pkg;

  localparam int unsigned FUNC_W  = 8;
  localparam int unsigned HS_W    = 81;
  localparam int unsigned LS_W    = 16;
  localparam int unsigned ENTRY_W = FUNC_W + HS_W + LS_W;

  localparam logic [FUNC_W-1:0] FUNC_HS     = 8'h01;
  localparam logic [FUNC_W-1:0] FUNC_LS     = 8'h02;
  localparam logic [FUNC_W-1:0] ACK_TIMEOUT = 8'hEE;
  localparam logic [FUNC_W-1:0] ACK_BADFUNC = 8'hEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_APPLY = 3'd2,
    ST_GAP   = 3'd3,
    ST_ACK   = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [HS_W-1:0]   hs;
    logic [LS_W-1:0]   ls;
  } cmd_entry_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered read data (updated on pop).
module cmd_fifo #(
  parameter int unsigned WIDTH = 105,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Full is judged on the current count, so a same-cycle pop never frees a slot for the push.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/uart_cmd_scheduler.sv
// Queues decoded UART commands and applies them to the HS/LS targets with timeout, settle gap and status ack.
// Optional statistics counters are built when CMD_STATS_EN is defined.
module uart_cmd_scheduler
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned CFG_TIMEOUT = 1000,
  parameter int unsigned APPLY_GAP   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  input  logic [FUNC_W-1:0] cmd_func,
  input  logic [HS_W-1:0]   cmd_hs_data,
  input  logic [LS_W-1:0]   cmd_ls_data,
  output logic              hs_cfg_valid,
  output logic [HS_W-1:0]   hs_cfg_data,
  input  logic              hs_cfg_ready,
  output logic              ls_cfg_valid,
  output logic [LS_W-1:0]   ls_cfg_data,
  input  logic              ls_cfg_ready,
  output logic              ack_valid,
  output logic [7:0]        ack_byte,
  input  logic              ack_ready,
  output logic              cmd_drop,
  output logic              busy
`ifdef CMD_STATS_EN
  ,
  output logic [15:0]       stat_ok,
  output logic [15:0]       stat_err,
  output logic [15:0]       stat_drop
`endif
);

  localparam int unsigned CNT_W = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned GAP_W = $clog2(APPLY_GAP) + 1;
  localparam logic [31:0]      TMO_LAST = 32'(CFG_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(APPLY_GAP - 1);

  sched_state_t      state_q, state_d;
  cmd_entry_t        fifo_wr, fifo_rd;
  logic              fifo_full, fifo_empty, fifo_pop, push_ok;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [31:0]       wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              hs_valid_d, ls_valid_d, ack_valid_d, drop_d, busy_d;
  logic [HS_W-1:0]   hs_data_d;
  logic [LS_W-1:0]   ls_data_d;
  logic [7:0]        ack_byte_d;
`ifdef CMD_STATS_EN
  logic [15:0]       stat_ok_d, stat_err_d, stat_drop_d;
`endif

  assign fifo_wr = '{func: cmd_func, hs: cmd_hs_data, ls: cmd_ls_data};
  assign push_ok = cmd_valid && !fifo_full;

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (cmd_valid),
    .pop       (fifo_pop),
    .wr_data   (fifo_wr),
    .rd_data   (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    func_d      = func_q;
    wait_cnt_d  = wait_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    hs_valid_d  = hs_cfg_valid;
    ls_valid_d  = ls_cfg_valid;
    hs_data_d   = hs_cfg_data;
    ls_data_d   = ls_cfg_data;
    ack_valid_d = ack_valid;
    ack_byte_d  = ack_byte;
    fifo_pop    = 1'b0;
    drop_d      = cmd_valid && fifo_full;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        func_d     = fifo_rd.func;
        hs_data_d  = fifo_rd.hs;
        ls_data_d  = fifo_rd.ls;
        wait_cnt_d = '0;
        if (fifo_rd.func == FUNC_HS) begin
          hs_valid_d = 1'b1;
          state_d    = ST_APPLY;
        end else if (fifo_rd.func == FUNC_LS) begin
          ls_valid_d = 1'b1;
          state_d    = ST_APPLY;
        end else begin
          ack_valid_d = 1'b1;
          ack_byte_d  = ACK_BADFUNC;
          state_d     = ST_ACK;
        end
      end
      ST_APPLY: begin
        if ((hs_cfg_valid && hs_cfg_ready) || (ls_cfg_valid && ls_cfg_ready)) begin
          hs_valid_d = 1'b0;
          ls_valid_d = 1'b0;
          ack_byte_d = func_q;
          gap_cnt_d  = '0;
          state_d    = ST_GAP;
        end else if (wait_cnt_q == TMO_LAST) begin
          hs_valid_d = 1'b0;
          ls_valid_d = 1'b0;
          ack_byte_d = ACK_TIMEOUT;
          gap_cnt_d  = '0;
          state_d    = ST_GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          ack_valid_d = 1'b1;
          state_d     = ST_ACK;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_ACK: begin
        if (ack_ready) begin
          ack_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Busy is registered from next values so it tracks the current state/occupancy exactly.
    fifo_cnt_d = fifo_cnt + CNT_W'(push_ok) - CNT_W'(fifo_pop);
    busy_d     = (state_d != ST_IDLE) || (fifo_cnt_d != '0);

`ifdef CMD_STATS_EN
    stat_ok_d   = stat_ok;
    stat_err_d  = stat_err;
    stat_drop_d = stat_drop;
    if (state_q == ST_ACK && ack_ready) begin
      if (ack_byte == ACK_TIMEOUT || ack_byte == ACK_BADFUNC) begin
        if (stat_err != 16'hFFFF) stat_err_d = stat_err + 16'd1;
      end else if (stat_ok != 16'hFFFF) begin
        stat_ok_d = stat_ok + 16'd1;
      end
    end
    if (cmd_drop && stat_drop != 16'hFFFF) stat_drop_d = stat_drop + 16'd1;
`endif
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      func_q       <= '0;
      wait_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      hs_cfg_valid <= 1'b0;
      ls_cfg_valid <= 1'b0;
      hs_cfg_data  <= '0;
      ls_cfg_data  <= '0;
      ack_valid    <= 1'b0;
      ack_byte     <= '0;
      cmd_drop     <= 1'b0;
      busy         <= 1'b0;
`ifdef CMD_STATS_EN
      stat_ok      <= '0;
      stat_err     <= '0;
      stat_drop    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      func_q       <= func_d;
      wait_cnt_q   <= wait_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      hs_cfg_valid <= hs_valid_d;
      ls_cfg_valid <= ls_valid_d;
      hs_cfg_data  <= hs_data_d;
      ls_cfg_data  <= ls_data_d;
      ack_valid    <= ack_valid_d;
      ack_byte     <= ack_byte_d;
      cmd_drop     <= drop_d;
      busy         <= busy_d;
`ifdef CMD_STATS_EN
      stat_ok      <= stat_ok_d;
      stat_err     <= stat_err_d;
      stat_drop    <= stat_drop_d;
`endif
    end
  end

endmodule
